// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
package intc_pkg;

  localparam int unsigned VecW    = 3;
  localparam int unsigned VectorW = 16;

  localparam logic [1:0] RegPend  = 2'd0;
  localparam logic [1:0] RegMask  = 2'd1;
  localparam logic [1:0] RegInsvc = 2'd2;
  localparam logic [1:0] RegEoi   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } state_e;

endpackage

// File: rtl/intc_if.sv
// CPU-side bus and interrupt handshake of the interrupt controller.
interface intc_if;
  import intc_pkg::*;

  logic [11:0]        address;
  logic [15:0]        wdata;
  logic               memwt;
  logic [15:0]        rdata;
  logic               sel;
  logic               intr;
  logic               intack;
  logic [VectorW-1:0] vector;

  modport master (
    output address, wdata, memwt, intack,
    input  rdata, sel, intr, vector
  );

  modport slave (
    input  address, wdata, memwt, intack,
    output rdata, sel, intr, vector
  );
endinterface

// File: rtl/intc_prio_enc.sv
// Priority encoder: first set request at or after the start index, wrapping around.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    req,
  input  logic [VecW-1:0] start,
  output logic            valid,
  output logic [VecW-1:0] idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < int'(N); i++) begin
      j = int'(start) + i;
      if (j >= int'(N)) j = j - int'(N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = VecW'(j);
      end
    end
  end

endmodule

// File: rtl/intc.sv
// Edge-triggered interrupt controller with memory-mapped PEND/MASK/INSVC/EOI registers.
// Define INTC_ROTATE_EN for rotating priority; otherwise the lowest index always wins.
module intc
  import intc_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  parameter logic [11:0] BASE = 12'hFF0
) (
  input logic            clk,
  input logic            rst_n,
  input logic [NSRC-1:0] irq,
  intc_if.slave          bus
);

  logic [NSRC-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [1:0]      warm_q;
  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, insvc_q;
  state_e          state_q;
  logic [VecW-1:0] vec_q;
  logic            intr_q;
  logic [11:0]     offset;
  logic            wr_pend, wr_mask, wr_eoi, ack;
  logic            win_valid;
  logic [VecW-1:0] win_idx, start;
  logic            unused_wdata;

  assign offset       = bus.address - BASE;
  assign bus.sel      = (offset < 12'd4);
  assign wr_pend      = bus.memwt && bus.sel && (offset[1:0] == RegPend);
  assign wr_mask      = bus.memwt && bus.sel && (offset[1:0] == RegMask);
  assign wr_eoi       = bus.memwt && bus.sel && (offset[1:0] == RegEoi);
  assign ack          = bus.intack && (state_q == StReq);
  assign unused_wdata = ^bus.wdata;

  // Edge detection stays off until the chain holds real samples, so an irq
  // already high when reset is released is not seen as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  assign rise = sync2_q & ~prev_q & {NSRC{warm_q == 2'd3}};

  // New edges are OR-ed last so they beat a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~bus.wdata[NSRC-1:0];
    if (ack) pend_d[vec_q] = 1'b0;
    pend_d = pend_d | rise;
    mask_d = wr_mask ? bus.wdata[NSRC-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

`ifdef INTC_ROTATE_EN
  logic [VecW-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (ack) begin
      ptr_q <= (vec_q == VecW'(NSRC - 1)) ? '0 : vec_q + 1'b1;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  intc_prio_enc #(
    .N(NSRC)
  ) u_prio_enc (
    .req  (pend_q & mask_q),
    .start(start),
    .valid(win_valid),
    .idx  (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      intr_q  <= 1'b0;
      insvc_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            vec_q   <= win_idx;
            intr_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (bus.intack) begin
            insvc_q[vec_q] <= 1'b1;
            intr_q         <= 1'b0;
            state_q        <= StService;
          end
        end
        StService: begin
          if (wr_eoi) begin
            insvc_q <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          intr_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.intr   = intr_q;
  assign bus.vector = (state_q == StReq) ? {{(VectorW - VecW){1'b0}}, vec_q} : '0;

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (offset[1:0])
        RegPend:  bus.rdata[NSRC-1:0] = pend_q;
        RegMask:  bus.rdata[NSRC-1:0] = mask_q;
        RegInsvc: bus.rdata[NSRC-1:0] = insvc_q;
        default:  bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: vector table plus hand-written multi-cycle sequences.
module tb_intc;
  import intc_pkg::*;

  localparam int unsigned NSRC = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NSRC-1:0] irq;

  intc_if bus ();

  intc #(
    .NSRC(NSRC),
    .BASE(12'hFF0)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .irq  (irq),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] mask;
    logic [7:0] irq;
    logic [7:0] exp_pend;
    logic       exp_intr;
    logic [2:0] exp_vec;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    irq         = '0;
    bus.memwt   = 1'b0;
    bus.intack  = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wr(input logic [1:0] off, input logic [15:0] data);
    bus.address = 12'hFF0 + 12'(off);
    bus.wdata   = data;
    bus.memwt   = 1'b1;
    tick();
    bus.memwt   = 1'b0;
    bus.address = '0;
  endtask

  task automatic rd(input logic [1:0] off, input logic [15:0] want, input string name);
    bus.address = 12'hFF0 + 12'(off);
    #1;
    check(name, bus.rdata, want);
    bus.address = '0;
  endtask

  task automatic service(input string name, output logic [2:0] got);
    logic        ok;
    logic [15:0] want;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.intr === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_intr_wait"}, 16'(ok), 16'd1);
    want = 16'hFFFF;
    if (exp_q.size() > 0) want = exp_q.pop_front();
    bus.intack = 1'b1;
    #1;
    check({name, "_vector"}, bus.vector, want);
    got = bus.vector[2:0];
    tick();
    bus.intack = 1'b0;
    check({name, "_intr_drop"}, 16'(bus.intr), 16'd0);
  endtask

  initial begin
    logic [2:0] got;
    logic [2:0] want_idx;
    rst_n       = 1'b0;
    irq         = '0;
    bus.memwt   = 1'b0;
    bus.intack  = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;

    tbl[0] = '{mask: 8'h04, irq: 8'h04, exp_pend: 8'h04, exp_intr: 1'b1, exp_vec: 3'd2};
    tbl[1] = '{mask: 8'hFF, irq: 8'h04, exp_pend: 8'h04, exp_intr: 1'b1, exp_vec: 3'd2};
    tbl[2] = '{mask: 8'hFF, irq: 8'h80, exp_pend: 8'h80, exp_intr: 1'b1, exp_vec: 3'd7};
    tbl[3] = '{mask: 8'h00, irq: 8'h08, exp_pend: 8'h08, exp_intr: 1'b0, exp_vec: 3'd0};
    tbl[4] = '{mask: 8'h0F, irq: 8'h30, exp_pend: 8'h30, exp_intr: 1'b0, exp_vec: 3'd0};
    tbl[5] = '{mask: 8'hFF, irq: 8'h22, exp_pend: 8'h22, exp_intr: 1'b1, exp_vec: 3'd1};
    tbl[6] = '{mask: 8'h0C, irq: 8'h0F, exp_pend: 8'h0F, exp_intr: 1'b1, exp_vec: 3'd2};

    // Reset state, decode window, stray intack
    do_reset();
    check("rst_intr", 16'(bus.intr), 16'd0);
    check("rst_vector", bus.vector, 16'h0000);
    rd(2'd0, 16'h0000, "rst_pend");
    rd(2'd1, 16'h0000, "rst_mask");
    rd(2'd2, 16'h0000, "rst_insvc");
    wr(2'd1, 16'hFFA5);
    rd(2'd1, 16'h00A5, "mask_rw_upper_zero");
    rd(2'd3, 16'h0000, "eoi_reads_zero");
    bus.address = 12'hFF3; #1 check("sel_top", 16'(bus.sel), 16'd1);
    bus.address = 12'hFF4; #1 check("sel_above", 16'(bus.sel), 16'd0);
    check("rdata_unsel", bus.rdata, 16'h0000);
    bus.address = 12'hFEF; #1 check("sel_below", 16'(bus.sel), 16'd0);
    bus.address = '0;
    bus.intack = 1'b1; tick(); bus.intack = 1'b0; tick();
    check("ack_in_idle_intr", 16'(bus.intr), 16'd0);
    rd(2'd2, 16'h0000, "ack_in_idle_insvc");

    // Table: latency, pending, masking, fixed lowest-index choice
    foreach (tbl[k]) begin
      do_reset();
      wr(2'd1, {8'h00, tbl[k].mask});
      irq = tbl[k].irq;
      repeat (3) tick();
      check($sformatf("t%0d_lat3", k), 16'(bus.intr), 16'd0);
      tick();
      check($sformatf("t%0d_lat4", k), 16'(bus.intr), 16'(tbl[k].exp_intr));
      rd(2'd0, {8'h00, tbl[k].exp_pend}, $sformatf("t%0d_pend", k));
      if (tbl[k].exp_intr) begin
        exp_q.push_back(16'(tbl[k].exp_vec));
        service($sformatf("t%0d", k), got);
        rd(2'd2, 16'h1 << tbl[k].exp_vec, $sformatf("t%0d_insvc", k));
        rd(2'd0, {8'h00, tbl[k].exp_pend & ~(8'h01 << tbl[k].exp_vec)},
           $sformatf("t%0d_pend_after", k));
        wr(2'd3, 16'h1234);
        rd(2'd2, 16'h0000, $sformatf("t%0d_insvc_eoi", k));
      end
      irq = '0;
      tick();
    end

    // Two simultaneous sources: lower index first, the other after EOI
    do_reset();
    wr(2'd1, 16'h00FF);
    irq = 8'h22;
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd5);
    service("pair_a", got);
    wr(2'd3, 16'h0000);
    service("pair_b", got);
    rd(2'd2, 16'h0020, "pair_b_insvc");
    wr(2'd3, 16'h0000);
    irq = '0;

    // Masked pending, then enabling; EOI while in REQ is ignored
    do_reset();
    irq = 8'h08;
    repeat (6) tick();
    check("masked_intr", 16'(bus.intr), 16'd0);
    rd(2'd0, 16'h0008, "masked_pend");
    wr(2'd1, 16'h0008);
    check("unmask_same", 16'(bus.intr), 16'd0);
    tick();
    check("unmask_next", 16'(bus.intr), 16'd1);
    wr(2'd3, 16'h0000);
    check("eoi_in_req", 16'(bus.intr), 16'd1);
    exp_q.push_back(16'd3);
    service("unmask", got);
    wr(2'd3, 16'h0000);
    irq = '0;

    // W1C in the cycle the synchronized edge arrives: set wins
    do_reset();
    irq = 8'h01;
    tick();
    tick();
    wr(2'd0, 16'h0001);
    rd(2'd0, 16'h0001, "set_beats_w1c");
    wr(2'd0, 16'h0001);
    rd(2'd0, 16'h0000, "w1c_clears");
    irq = '0;

    // Clearing PEND and MASK during REQ keeps the latched vector
    do_reset();
    wr(2'd1, 16'h0004);
    irq = 8'h04;
    repeat (5) tick();
    wr(2'd0, 16'h0004);
    wr(2'd1, 16'h0000);
    check("req_hold_intr", 16'(bus.intr), 16'd1);
    exp_q.push_back(16'd2);
    service("req_hold", got);
    rd(2'd2, 16'h0004, "req_hold_insvc");
    wr(2'd3, 16'h0000);
    irq = '0;

    // Both of irq[0], irq[1] kept pending: order depends on priority mode
    do_reset();
    wr(2'd1, 16'h0003);
    irq = 8'h03;
    for (int k = 0; k < 4; k++) begin
`ifdef INTC_ROTATE_EN
      want_idx = 3'(k % 2);
`else
      want_idx = 3'd0;
`endif
      exp_q.push_back(16'(want_idx));
      service($sformatf("order%0d", k), got);
      irq[want_idx] = 1'b0;
      repeat (2) tick();
      irq[want_idx] = 1'b1;
      repeat (4) tick();
      wr(2'd3, 16'h0000);
    end
    irq = '0;

    // Asynchronous reset while in SERVICE, irq held high across release
    do_reset();
    wr(2'd1, 16'h00FF);
    irq = 8'h10;
    exp_q.push_back(16'd4);
    service("svc_rst", got);
    rd(2'd2, 16'h0010, "svc_rst_insvc_before");
    #2 rst_n = 1'b0;
    #1 check("svc_rst_intr", 16'(bus.intr), 16'd0);
    rd(2'd2, 16'h0000, "svc_rst_insvc");
    rd(2'd1, 16'h0000, "svc_rst_mask");
    #2 rst_n = 1'b1;
    tick();
    wr(2'd1, 16'h00FF);
    repeat (8) tick();
    check("rel_no_edge_intr", 16'(bus.intr), 16'd0);
    rd(2'd0, 16'h0000, "rel_no_edge_pend");
    irq = '0;

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
